// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD SPI FIFO writer: engine states,
// DC pin encodings and the parameter-legality predicate.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } eng_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Power-of-two depth keeps pointer wrap a plain binary overflow.
    function automatic bit params_legal(input int data_w, input int depth, input int clk_div);
        return (data_w >= 1) && (depth >= 2) && (depth <= 256) &&
               ((depth & (depth - 1)) == 0) && (clk_div >= 1);
    endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a sticky overflow flag.
// The head word is presented combinationally on rdata.
module lcd_sync_fifo
    import lcd_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
        // A rejected push wins over a same-cycle clear.
        ovf_d    = (push & full_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level define validity,
    // and a reset on the array would block RAM inference.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata    = mem[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule

// File: rtl/lcd_spi_fifo_writer.sv
// LCD serial writer: a FIFO of {dc, payload} words drained by a mode-0,
// MSB-first SPI shift engine; back-to-back words are sent as one cs-low burst.
module lcd_spi_fifo_writer
    import lcd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [DATA_W:0]          data,
    input  logic                     en_write,
    input  logic                     clr_ovf,
    output logic                     wr_done,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle,
    output logic                     cs,
    output logic                     dc,
    output logic                     sclk,
    output logic                     mosi
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (!params_legal(DATA_W, DEPTH, CLK_DIV)) begin : g_param_check
        $error("lcd_spi_fifo_writer: illegal DATA_W/DEPTH/CLK_DIV combination");
    end

    logic [DATA_W:0] fifo_rdata;
    logic            fifo_pop;
    logic            fifo_empty;

    lcd_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .push     (en_write),
        .wdata    (data),
        .pop      (fifo_pop),
        .clr_ovf  (clr_ovf),
        .rdata    (fifo_rdata),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow),
        .level    (level)
    );

    eng_state_e        state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              cs_q, cs_d;
    logic              dc_q, dc_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              wr_done_q, wr_done_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        div_d     = div_q;
        bits_d    = bits_q;
        shreg_d   = shreg_q;
        cs_d      = cs_q;
        dc_d      = dc_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        wr_done_d = 1'b0;
        fifo_pop  = 1'b0;

        // Popping from IDLE or DONE loads the head word so LOAD already drives it.
        if ((state_q == ST_IDLE || state_q == ST_DONE) && !fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_LOAD;
            shreg_d  = fifo_rdata[DATA_W-1:0];
            dc_d     = fifo_rdata[DATA_W];
            mosi_d   = fifo_rdata[DATA_W-1];
            cs_d     = 1'b0;
            sclk_d   = 1'b0;
            div_d    = '0;
            bits_d   = BW'(DATA_W - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cs_d   = 1'b1;
                    sclk_d = 1'b0;
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_d = div_q + DW'(1);
                    end else begin
                        div_d = '0;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                        end else if (bits_q == '0) begin
                            sclk_d    = 1'b0;
                            state_d   = ST_DONE;
                            wr_done_d = 1'b1;
                        end else begin
                            sclk_d  = 1'b0;
                            bits_d  = bits_q - BW'(1);
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_d[DATA_W-1];
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cs_d    = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bits_q    <= '0;
            shreg_q   <= '0;
            cs_q      <= 1'b1;
            dc_q      <= DC_CMD;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            shreg_q   <= shreg_d;
            cs_q      <= cs_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign empty   = fifo_empty;
    assign idle    = (state_q == ST_IDLE) && fifo_empty;
    assign wr_done = wr_done_q;
    assign cs      = cs_q;
    assign dc      = dc_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_lcd_spi_fifo_writer.sv
// Bench for lcd_spi_fifo_writer: a negedge SPI monitor rebuilds each word and
// compares it at wr_done against a queue of words accepted by the stimulus.
module tb_lcd_spi_fifo_writer;
    import lcd_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int WORD_CYCLES = 1 + 2 * DATA_W * CLK_DIV;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [DATA_W:0]   data;
    logic              en_write;
    logic              clr_ovf;
    logic              wr_done;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [LW-1:0]     level;
    logic              idle;
    logic              cs;
    logic              dc;
    logic              sclk;
    logic              mosi;

    lcd_spi_fifo_writer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .en_write  (en_write),
        .clr_ovf   (clr_ovf),
        .wr_done   (wr_done),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .level     (level),
        .idle      (idle),
        .cs        (cs),
        .dc        (dc),
        .sclk      (sclk),
        .mosi      (mosi)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W:0] exp_q[$];

    // SPI monitor state
    logic [DATA_W-1:0] rx_byte;
    logic [DATA_W:0]   mon_exp;
    int                rx_bits     = 0;
    logic              prev_sclk   = 1'b0;
    int                wd_count    = 0;
    int                sclk_rises  = 0;
    int                cyc         = 0;
    int                last_rise   = 0;

    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            rx_bits   = 0;
            prev_sclk = 1'b0;
        end else begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (rx_bits > 0) begin
                    tests_run++;
                    if (cyc - last_rise != 2 * CLK_DIV) begin
                        tests_failed++;
                        $display("FAIL sclk_period: got %0d cycles, expected %0d", cyc - last_rise, 2 * CLK_DIV);
                    end
                end
                last_rise = cyc;
                rx_byte   = {rx_byte[DATA_W-2:0], mosi};
                rx_bits++;
                sclk_rises++;
            end
            prev_sclk = sclk;
            if (wr_done === 1'b1) begin
                wd_count++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL word_unexpected: got %0h, expected no word", {dc, rx_byte});
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({dc, rx_byte} !== mon_exp || rx_bits != DATA_W) begin
                        tests_failed++;
                        $display("FAIL word_rx: got %0h (%0d bits), expected %0h (%0d bits)",
                                 {dc, rx_byte}, rx_bits, mon_exp, DATA_W);
                    end
                end
                rx_bits = 0;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_wd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && wd_count < target; i++) begin
            tick();
        end
        ok = (wd_count >= target);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        en_write  = 1'b0;
        clr_ovf   = 1'b0;
        data      = '0;
        repeat (3) tick();
        tests_run++; if (cs !== 1'b1)      begin tests_failed++; $display("FAIL reset_cs: got %b, expected 1", cs); end
        tests_run++; if (sclk !== 1'b0)    begin tests_failed++; $display("FAIL reset_sclk: got %b, expected 0", sclk); end
        tests_run++; if (mosi !== 1'b0)    begin tests_failed++; $display("FAIL reset_mosi: got %b, expected 0", mosi); end
        tests_run++; if (dc !== DC_CMD)    begin tests_failed++; $display("FAIL reset_dc: got %b, expected 0", dc); end
        tests_run++; if (wr_done !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_done: got %b, expected 0", wr_done); end
        tests_run++; if (empty !== 1'b1)   begin tests_failed++; $display("FAIL reset_empty: got %b, expected 1", empty); end
        tests_run++; if (full !== 1'b0)    begin tests_failed++; $display("FAIL reset_full: got %b, expected 0", full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        tests_run++; if (level !== '0)     begin tests_failed++; $display("FAIL reset_level: got %0d, expected 0", level); end
        tests_run++; if (idle !== 1'b1)    begin tests_failed++; $display("FAIL reset_idle: got %b, expected 1", idle); end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cmd();
        int n;
        int base_rises;
        data     = 9'h036;
        en_write = 1'b1;
        exp_q.push_back(9'h036);
        tick();
        en_write = 1'b0;
        tests_run++;
        if (cs !== 1'b1) begin tests_failed++; $display("FAIL single_cs_first_edge: got %b, expected 1", cs); end
        tick();
        base_rises = sclk_rises;
        tests_run++;
        if (cs !== 1'b0 || dc !== DC_CMD) begin
            tests_failed++;
            $display("FAIL single_load: got cs=%b dc=%b, expected cs=0 dc=0", cs, dc);
        end
        n = 0;
        while (wr_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != WORD_CYCLES) begin tests_failed++; $display("FAIL single_latency: got %0d cycles, expected %0d", n, WORD_CYCLES); end
        tests_run++;
        if (sclk_rises - base_rises != DATA_W) begin
            tests_failed++;
            $display("FAIL single_sclk_pulses: got %0d, expected %0d", sclk_rises - base_rises, DATA_W);
        end
        tick();
        tests_run++;
        if (wr_done !== 1'b0 || cs !== 1'b1 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_after_done: got wr_done=%b cs=%b idle=%b, expected 0 1 1", wr_done, cs, idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W:0] words[3];
        int  base_wd;
        int  cs_breaks;
        bit  seen_low;
        bit  ok;
        words = '{9'h12A, 9'h100, 9'h17F};
        base_wd = wd_count;
        for (int i = 0; i < 3; i++) begin
            data     = words[i];
            en_write = 1'b1;
            exp_q.push_back(words[i]);
            tick();
        end
        en_write  = 1'b0;
        cs_breaks = 0;
        seen_low  = 1'b0;
        ok        = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wd_count >= base_wd + 3) begin
                ok = 1'b1;
                break;
            end
            if (cs === 1'b0) seen_low = 1'b1;
            else if (seen_low) cs_breaks++;
            tick();
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL burst_timeout: got %0d words, expected 3", wd_count - base_wd); end
        tests_run++;
        if (cs_breaks != 0 || !seen_low) begin
            tests_failed++;
            $display("FAIL burst_cs_low: got %0d cs-high cycles, expected 0", cs_breaks);
        end
        repeat (3) tick();
        tests_run++;
        if (wd_count - base_wd != 3 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d words idle=%b, expected 3 words idle=1", wd_count - base_wd, idle);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W:0] words[6];
        int base_wd;
        bit ok;
        words = '{9'h0A1, 9'h1B2, 9'h0C3, 9'h1D4, 9'h0E5, 9'h1F6};
        base_wd = wd_count;
        for (int i = 0; i < 6; i++) begin
            data     = words[i];
            en_write = 1'b1;
            if (i < 5) exp_q.push_back(words[i]);
            tick();
            if (i == 4) begin
                tests_run++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_fifth_push: got full=%b ovf=%b, expected 1 0", full, overflow);
                end
            end
        end
        en_write = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            tests_failed++;
            $display("FAIL ovf_set: got ovf=%b level=%0d, expected 1 %0d", overflow, level, DEPTH);
        end
        data     = 9'h1EE;
        en_write = 1'b1;
        clr_ovf  = 1'b1;
        tick();
        en_write = 1'b0;
        clr_ovf  = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            tests_failed++;
            $display("FAIL ovf_set_beats_clear: got ovf=%b level=%0d, expected 1 %0d", overflow, level, DEPTH);
        end
        tick();
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
        wait_wd(base_wd + 5, 5 * (WORD_CYCLES + 2) + 50, ok);
        repeat (WORD_CYCLES + 5) tick();
        tests_run++;
        if (!ok || wd_count - base_wd != 5 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ovf_words: got %0d words (%0d pending), expected 5 (0 pending)", wd_count - base_wd, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        int base_rises;
        int hold_wd;
        int hold_rises;
        bit reached;
        base_rises = sclk_rises;
        for (int i = 0; i < 3; i++) begin
            data     = 9'(9'h0C0 + i);
            en_write = 1'b1;
            exp_q.push_back(9'(9'h0C0 + i));
            tick();
        end
        en_write = 1'b0;
        reached  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sclk_rises >= base_rises + 5) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!reached) begin tests_failed++; $display("FAIL midrst_timeout: got %0d rises, expected 5", sclk_rises - base_rises); end
        sys_rst_n = 1'b0;
        hold_wd   = wd_count;
        tick();
        tests_run++;
        if (cs !== 1'b1 || sclk !== 1'b0 || level !== '0 || empty !== 1'b1 || wr_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_state: got cs=%b sclk=%b level=%0d empty=%b wr_done=%b, expected 1 0 0 1 0",
                     cs, sclk, level, empty, wr_done);
        end
        sys_rst_n = 1'b1;
        exp_q.delete();
        tick();
        hold_rises = sclk_rises;
        repeat (2 * WORD_CYCLES) tick();
        tests_run++;
        if (wd_count != hold_wd || sclk_rises != hold_rises || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_quiet: got %0d wr_done %0d rises idle=%b, expected 0 0 1",
                     wd_count - hold_wd, sclk_rises - hold_rises, idle);
        end
    endtask

    task automatic test_wrap();
        int base_wd;
        int max_level;
        int timeouts;
        max_level = 0;
        timeouts  = 0;
        for (int b = 0; b < 3; b++) begin
            base_wd = wd_count;
            for (int k = 0; k < 3; k++) begin
                data     = 9'(9'h101 + b * 3 + k);
                en_write = 1'b1;
                exp_q.push_back(9'(9'h101 + b * 3 + k));
                tick();
                if (int'(level) > max_level) max_level = int'(level);
            end
            en_write = 1'b0;
            for (int i = 0; i < 300 && wd_count < base_wd + 3; i++) begin
                tick();
                if (int'(level) > max_level) max_level = int'(level);
            end
            if (wd_count < base_wd + 3) timeouts++;
        end
        repeat (3) tick();
        tests_run++;
        if (timeouts != 0) begin tests_failed++; $display("FAIL wrap_timeout: got %0d stalled batches, expected 0", timeouts); end
        tests_run++;
        if (max_level > DEPTH) begin tests_failed++; $display("FAIL wrap_level: got max %0d, expected <= %0d", max_level, DEPTH); end
        tests_run++;
        if (empty !== 1'b1 || idle !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_end: got empty=%b idle=%b pending=%0d, expected 1 1 0", empty, idle, exp_q.size());
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        en_write  = 1'b0;
        clr_ovf   = 1'b0;
        data      = '0;
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
